// File: rtl/disp_pkg.sv
// ----------------------------------------------------------------------------
// disp_pkg
// Shared types and constants for the 4-digit display path.
//   disp_state_t : scheduler FSM states (IDLE, NOTE, MSG)
//   DIGITS       : number of display digits
//   EN_ALL/NONE  : digit-enable patterns (bit3 = leftmost, 1 = lit)
//   disp_word_t  : four hex nibbles, [15:12] leftmost
// ----------------------------------------------------------------------------
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        MSG  = 2'd2
    } disp_state_t;

    localparam int DIGITS = 4;

    localparam logic [DIGITS-1:0] EN_ALL  = 4'b1111;
    localparam logic [DIGITS-1:0] EN_NONE = 4'b0000;

    typedef logic [15:0] disp_word_t;

endpackage

// File: rtl/display_scheduler_hold_timer.sv
// ----------------------------------------------------------------------------
// hold_timer
// Down-counter that measures how long a message stays on the display.
// A load sets the count to HOLD_CYCLES-1; otherwise the count decrements
// once per clock until it reaches 0 and then rests there (no wrap).
//
// Parameters:
//   HOLD_CYCLES : cycles a message is visible, legal range >= 1
// Ports:
//   clk     in  clock
//   clear_n in  asynchronous active-low reset (count -> 0)
//   load    in  restart the hold period
//   done    out high while the count is 0
// ----------------------------------------------------------------------------
module hold_timer #(
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic clear_n,
    input  logic load,
    output logic done
);

    localparam int W = $clog2(HOLD_CYCLES + 1);
    localparam logic [W-1:0] LOAD_VAL = W'(HOLD_CYCLES - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= LOAD_VAL;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign done = (r_count == '0);

endmodule

// File: rtl/display_scheduler.sv
// ----------------------------------------------------------------------------
// display_scheduler
// Owns the 4-digit display path. Arbitrates between a continuous note-name
// source and one-shot status messages, holds each message for HOLD_CYCLES
// clocks and drives registered digits/enables into display_controller.
//
// Optional feature (macro DISP_BLINK_EN): messages blink, toggling every
// 2^BLINK_BIT cycles, starting lit. Without the macro messages are steady.
//
// Parameters:
//   HOLD_CYCLES : message visible time in clocks (>= 1)
//   BLINK_BIT   : blink counter bit (only with DISP_BLINK_EN)
// Ports:
//   clk                  in   clock
//   clear_n              in   asynchronous active-low reset
//   note_valid           in   key held, note_code meaningful
//   note_code[15:0]      in   note nibbles, [15:12] leftmost
//   msg_req              in   message request (level)
//   msg_data[15:0]       in   message nibbles, [15:12] leftmost
//   msg_ack              out  one-cycle pulse when msg_data is latched
//   busy                 out  high while in MSG
//   digit3..digit0[3:0]  out  digit values to display_controller
//   enables[3:0]         out  digit enables, bit3 leftmost, 1 = lit
//   dbg_state[1:0]       out  current FSM state (disp_state_t encoding)
//
// Handshake: msg_req is a level sampled on every clock edge. Each edge with
// msg_req high latches msg_data, pulses msg_ack for one cycle and restarts
// the hold period; a requester must drop msg_req once it sees msg_ack or it
// will be acked again on every cycle.
// ----------------------------------------------------------------------------
module display_scheduler
    import disp_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000
`ifdef DISP_BLINK_EN
    ,
    parameter int BLINK_BIT   = 23
`endif
) (
    input  logic        clk,
    input  logic        clear_n,
    input  logic        note_valid,
    input  logic [15:0] note_code,
    input  logic        msg_req,
    input  logic [15:0] msg_data,
    output logic        msg_ack,
    output logic        busy,
    output logic [3:0]  digit3,
    output logic [3:0]  digit2,
    output logic [3:0]  digit1,
    output logic [3:0]  digit0,
    output logic [3:0]  enables,
    output logic [1:0]  dbg_state
);

    disp_state_t       r_state;
    disp_word_t        r_digits;
    logic [DIGITS-1:0] r_enables;
    logic              r_ack;
    logic              r_busy;
    logic              w_done;
    logic [DIGITS-1:0] w_msg_en;

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk     (clk),
        .clear_n (clear_n),
        .load    (msg_req),
        .done    (w_done)
    );

`ifdef DISP_BLINK_EN
    logic [BLINK_BIT:0] r_blink_cnt;
    logic [BLINK_BIT:0] w_blink_next;

    // Cleared on every message entry so each message starts lit.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_blink_cnt <= '0;
        end else if (msg_req) begin
            r_blink_cnt <= '0;
        end else begin
            r_blink_cnt <= w_blink_next;
        end
    end

    // Enables are registered, so they follow the counter value that is
    // being written on the same edge.
    assign w_blink_next = r_blink_cnt + 1'b1;
    assign w_msg_en     = {DIGITS{~w_blink_next[BLINK_BIT]}};
`else
    assign w_msg_en = EN_ALL;
`endif

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state   <= IDLE;
            r_digits  <= '0;
            r_enables <= EN_NONE;
            r_ack     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            if (msg_req) begin
                // Message entry or restart, from any state.
                r_state   <= MSG;
                r_digits  <= msg_data;
                r_enables <= EN_ALL;
                r_ack     <= 1'b1;
                r_busy    <= 1'b1;
            end else begin
                case (r_state)
                    MSG: begin
                        if (w_done) begin
                            r_busy <= 1'b0;
                            if (note_valid) begin
                                r_state   <= NOTE;
                                r_digits  <= note_code;
                                r_enables <= EN_ALL;
                            end else begin
                                r_state   <= IDLE;
                                r_digits  <= '0;
                                r_enables <= EN_NONE;
                            end
                        end else begin
                            // Digits stay frozen during the hold.
                            r_enables <= w_msg_en;
                        end
                    end
                    default: begin
                        // IDLE and NOTE share the same follow-the-key logic.
                        if (note_valid) begin
                            r_state   <= NOTE;
                            r_digits  <= note_code;
                            r_enables <= EN_ALL;
                        end else begin
                            r_state   <= IDLE;
                            r_digits  <= '0;
                            r_enables <= EN_NONE;
                        end
                    end
                endcase
            end
        end
    end

    assign msg_ack   = r_ack;
    assign busy      = r_busy;
    assign digit3    = r_digits[15:12];
    assign digit2    = r_digits[11:8];
    assign digit1    = r_digits[7:4];
    assign digit0    = r_digits[3:0];
    assign enables   = r_enables;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_display_scheduler.sv
// ----------------------------------------------------------------------------
// tb_display_scheduler
// Directed bench for display_scheduler with HOLD_CYCLES = 8, BLINK_BIT = 2.
// Observed word layout: {msg_ack, busy, enables[3:0], digits[15:0]}.
// ----------------------------------------------------------------------------
module tb_display_scheduler;

    localparam int HOLD = 8;

    logic        clk;
    logic        clear_n;
    logic        note_valid;
    logic [15:0] note_code;
    logic        msg_req;
    logic [15:0] msg_data;
    logic        msg_ack;
    logic        busy;
    logic [3:0]  digit3, digit2, digit1, digit0;
    logic [3:0]  enables;
    logic [1:0]  dbg_state;

    logic [21:0] obs;
    logic [21:0] exp_w;

    int n_pass  = 0;
    int n_total = 0;

    assign obs = {msg_ack, busy, enables, digit3, digit2, digit1, digit0};

    display_scheduler #(
        .HOLD_CYCLES (HOLD)
`ifdef DISP_BLINK_EN
        ,
        .BLINK_BIT   (2)
`endif
    ) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .note_valid (note_valid),
        .note_code  (note_code),
        .msg_req    (msg_req),
        .msg_data   (msg_data),
        .msg_ack    (msg_ack),
        .busy       (busy),
        .digit3     (digit3),
        .digit2     (digit2),
        .digit1     (digit1),
        .digit0     (digit0),
        .enables    (enables),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model helpers ----------------
    // Expected enables on the k-th visible cycle of a message (k = 0 at entry).
    function automatic logic [3:0] msg_en(input int k);
`ifdef DISP_BLINK_EN
        return ((k % 8) < 4) ? 4'b1111 : 4'b0000;
`else
        return (k >= 0) ? 4'b1111 : 4'b1111;
`endif
    endfunction

    function automatic logic [21:0] mk(input logic ack, input logic bsy,
                                       input logic [3:0] en, input logic [15:0] d);
        return {ack, bsy, en, d};
    endfunction

    // One clock, then sample 1 ns after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_n    = 1'b0;
        note_valid = 1'b0;
        note_code  = 16'h0;
        msg_req    = 1'b1;       // must be ignored while in reset
        msg_data   = 16'hDEAD;
        repeat (2) step();
        exp_w = mk(1'b0, 1'b0, 4'b0000, 16'h0000);
        n_total++;
        if (obs !== exp_w) $display("FAIL reset_outputs: got %h want %h", obs, exp_w);
        else n_pass++;
        n_total++;
        if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dbg_state);
        else n_pass++;
        msg_req = 1'b0;
        clear_n = 1'b1;
        step();
        n_total++;
        if (obs !== exp_w) $display("FAIL reset_release_idle: got %h want %h", obs, exp_w);
        else n_pass++;
    endtask

    task automatic test_note();
        note_valid = 1'b1;
        note_code  = 16'h1A3C;
        step();
        exp_w = mk(1'b0, 1'b0, 4'b1111, 16'h1A3C);
        n_total++;
        if (obs !== exp_w) $display("FAIL note_show: got %h want %h", obs, exp_w);
        else n_pass++;
        note_code = 16'h2B4D;    // digits follow note_code every edge
        step();
        exp_w = mk(1'b0, 1'b0, 4'b1111, 16'h2B4D);
        n_total++;
        if (obs !== exp_w) $display("FAIL note_follow: got %h want %h", obs, exp_w);
        else n_pass++;
        note_valid = 1'b0;
        step();
        exp_w = mk(1'b0, 1'b0, 4'b0000, 16'h0000);
        n_total++;
        if (obs !== exp_w) $display("FAIL note_blank: got %h want %h", obs, exp_w);
        else n_pass++;
    endtask

    task automatic test_msg_from_note();
        note_valid = 1'b1;
        note_code  = 16'h1A3C;
        step();
        msg_req  = 1'b1;
        msg_data = 16'hBEEF;
        step();
        msg_req  = 1'b0;
        msg_data = 16'h1234;     // mid-hold change must not show
        for (int k = 0; k < HOLD; k++) begin
            exp_w = mk(k == 0, 1'b1, msg_en(k), 16'hBEEF);
            n_total++;
            if (obs !== exp_w) $display("FAIL msg_hold k=%0d: got %h want %h", k, obs, exp_w);
            else n_pass++;
            step();
        end
        exp_w = mk(1'b0, 1'b0, 4'b1111, 16'h1A3C);
        n_total++;
        if (obs !== exp_w) $display("FAIL msg_return_note: got %h want %h", obs, exp_w);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        note_valid = 1'b0;
        step();
        n_total++;
        if (dbg_state !== 2'd0) $display("FAIL simul_pre_idle: got %0d want 0", dbg_state);
        else n_pass++;
        note_valid = 1'b1;
        note_code  = 16'h9ABC;
        msg_req    = 1'b1;
        msg_data   = 16'h5678;
        step();
        msg_req = 1'b0;
        for (int k = 0; k < HOLD; k++) begin
            exp_w = mk(k == 0, 1'b1, msg_en(k), 16'h5678);
            n_total++;
            if (obs !== exp_w) $display("FAIL simul_hold k=%0d: got %h want %h", k, obs, exp_w);
            else n_pass++;
            step();
        end
        exp_w = mk(1'b0, 1'b0, 4'b1111, 16'h9ABC);
        n_total++;
        if (obs !== exp_w) $display("FAIL simul_to_note: got %h want %h", obs, exp_w);
        else n_pass++;
    endtask

    task automatic test_rerequest();
        msg_req  = 1'b1;
        msg_data = 16'hBEEF;
        step();
        msg_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp_w = mk(k == 0, 1'b1, msg_en(k), 16'hBEEF);
            n_total++;
            if (obs !== exp_w) $display("FAIL rereq_first k=%0d: got %h want %h", k, obs, exp_w);
            else n_pass++;
            if (k == 4) begin
                msg_req  = 1'b1;
                msg_data = 16'h0042;
            end
            step();
            msg_req = 1'b0;
        end
        for (int k = 0; k < HOLD; k++) begin
            exp_w = mk(k == 0, 1'b1, msg_en(k), 16'h0042);
            n_total++;
            if (obs !== exp_w) $display("FAIL rereq_second k=%0d: got %h want %h", k, obs, exp_w);
            else n_pass++;
            step();
        end
        exp_w = mk(1'b0, 1'b0, 4'b1111, 16'h9ABC);
        n_total++;
        if (obs !== exp_w) $display("FAIL rereq_to_note: got %h want %h", obs, exp_w);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [3];
        vals[0] = 16'h1111;
        vals[1] = 16'h2222;
        vals[2] = 16'h3333;
        note_valid = 1'b0;
        msg_req    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            msg_data = vals[i];
            step();
            exp_w = mk(1'b1, 1'b1, 4'b1111, vals[i]);
            n_total++;
            if (obs !== exp_w) $display("FAIL b2b_ack i=%0d: got %h want %h", i, obs, exp_w);
            else n_pass++;
        end
        msg_req = 1'b0;
        repeat (HOLD - 1) step();
        exp_w = mk(1'b0, 1'b1, msg_en(HOLD - 1), 16'h3333);
        n_total++;
        if (obs !== exp_w) $display("FAIL b2b_last_hold: got %h want %h", obs, exp_w);
        else n_pass++;
        step();
        exp_w = mk(1'b0, 1'b0, 4'b0000, 16'h0000);
        n_total++;
        if (obs !== exp_w) $display("FAIL b2b_to_idle: got %h want %h", obs, exp_w);
        else n_pass++;
    endtask

    task automatic test_reset_mid_msg();
        note_valid = 1'b1;
        note_code  = 16'h7777;
        msg_req    = 1'b1;
        msg_data   = 16'hCAFE;
        step();
        msg_req = 1'b0;
        repeat (2) step();       // now on hold cycle 3
        clear_n = 1'b0;
        #1;
        exp_w = mk(1'b0, 1'b0, 4'b0000, 16'h0000);
        n_total++;
        if (obs !== exp_w) $display("FAIL midmsg_reset: got %h want %h", obs, exp_w);
        else n_pass++;
        note_valid = 1'b0;
        step();
        clear_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++;
            if (obs !== exp_w || dbg_state !== 2'd0)
                $display("FAIL midmsg_stay_idle i=%0d: got %h st %0d want %h st 0",
                         i, obs, dbg_state, exp_w);
            else n_pass++;
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_note();
        test_msg_from_note();
        test_simultaneous();
        test_rerequest();
        test_back_to_back();
        test_reset_mid_msg();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
